// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave with TX/RX FIFOs.
//   spi_state_e  : frame state (IDLE between frames, SHIFT inside a frame)
//   bit_order_e  : serial bit order, compared against the LSB_FIRST parameter
//   level_w()    : width of a FIFO occupancy count for a given depth
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  typedef enum bit {
    ORD_MSB = 1'b0,
    ORD_LSB = 1'b1
  } bit_order_e;

  // An occupancy of 0..depth needs one more code than a pointer does.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO used for both the TX and RX queues of spi_slave_fifo.
//   clk, rst_n   : clock (posedge) and asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full, unless popping)
//   pop          : read request (ignored when empty)
//   rdata        : current head entry (zero after reset)
//   full, empty  : occupancy flags
//   level        : number of stored entries, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [DATA_W-1:0]                   wdata,
  input  logic                                pop,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                full,
  output logic                                empty,
  output logic [level_w(FIFO_DEPTH)-1:0]      level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = level_w(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == LW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign level = count_q;

  // A push into a full FIFO is accepted when the same edge pops the head.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave (mode 0 style, posedge sclk only) with TX and RX FIFOs.
//   sclk, reset          : sole clock and asynchronous active-low reset
//   cs, mosi, miso       : active-low chip select, serial in, serial out
//   tx_data/valid/ready  : host push into the TX FIFO
//   rx_data/valid/ready  : host pop from the RX FIFO
//   busy                 : a frame is in progress
//   tx_level, rx_level   : FIFO occupancies
//   tx_underrun, rx_overrun, clr_err : sticky error flags and their clear
// Build option: define SPI_SLAVE_ERR_EN to get sticky error registers;
// otherwise both flags read 0 and clr_err is ignored.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                           sclk,
  input  logic                           reset,
  input  logic                           cs,
  input  logic                           mosi,
  output logic                           miso,
  input  logic [DATA_W-1:0]              tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic [DATA_W-1:0]              rx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic                           busy,
  output logic [level_w(FIFO_DEPTH)-1:0] tx_level,
  output logic [level_w(FIFO_DEPTH)-1:0] rx_level,
  output logic                           tx_underrun,
  output logic                           rx_overrun,
  input  logic                           clr_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam bit          LSB   = (LSB_FIRST == ORD_LSB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_loaded_q, tx_loaded_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;

  logic [DATA_W-1:0] tx_head, tx_shifted, rx_next;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              underrun_set, overrun_set;

  // TX leaves from the end nearest miso; RX enters at the opposite end so the
  // received word lines up bit-for-bit with what the master transmitted.
  assign tx_shifted = LSB ? (tx_shift_q >> 1) : (tx_shift_q << 1);
  assign rx_next    = LSB ? {mosi, rx_shift_q[DATA_W-1:1]}
                          : {rx_shift_q[DATA_W-2:0], mosi};

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  spi_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (sclk),
    .rst_n(reset),
    .push (tx_push),
    .wdata(tx_data),
    .pop  (tx_pop),
    .rdata(tx_head),
    .full (tx_full),
    .empty(tx_empty),
    .level(tx_level)
  );

  spi_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (sclk),
    .rst_n(reset),
    .push (rx_push),
    .wdata(rx_next),
    .pop  (rx_pop),
    .rdata(rx_data),
    .full (rx_full),
    .empty(rx_empty),
    .level(rx_level)
  );

  // State register
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      tx_loaded_q <= 1'b0;
      rx_shift_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_loaded_q <= tx_loaded_d;
      rx_shift_q  <= rx_shift_d;
    end
  end

  // Next state and shift datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_shift_d   = tx_shift_q;
    tx_loaded_d  = tx_loaded_q;
    rx_shift_d   = rx_shift_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs) begin
          // First bit edge: the word preloaded on earlier idle edges is
          // committed here, so it is only popped if it was actually loaded.
          rx_shift_d   = rx_next;
          tx_shift_d   = tx_shifted;
          tx_pop       = tx_loaded_q;
          underrun_set = !tx_loaded_q;
          cnt_d        = CNT_W'(1);
          state_d      = SHIFT;
        end else begin
          tx_shift_d  = tx_empty ? '0 : tx_head;
          tx_loaded_d = !tx_empty;
        end
      end
      SHIFT: begin
        if (cs) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rx_shift_d = rx_next;
          tx_shift_d = tx_shifted;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // Reload here so a back-to-back frame has its bit 0 on miso
            // before the next edge.
            rx_push     = 1'b1;
            tx_shift_d  = tx_empty ? '0 : tx_head;
            tx_loaded_d = !tx_empty;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign overrun_set = rx_push && rx_full && !rx_pop;

  // Outputs
  always_comb begin
    miso = 1'b0;
    if (!cs) begin
      miso = LSB ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
    end
    busy = (state_q == SHIFT);
  end

`ifdef SPI_SLAVE_ERR_EN
  logic underrun_q, underrun_d;
  logic overrun_q, overrun_d;

  // A new error on the same edge as clr_err wins.
  always_comb begin
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    if (clr_err) begin
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (underrun_set) underrun_d = 1'b1;
    if (overrun_set)  overrun_d  = 1'b1;
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
`else
  logic unused_err;
  assign unused_err  = ^{clr_err, underrun_set, overrun_set};
  assign tx_underrun = 1'b0;
  assign rx_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
module tb_spi_slave_fifo;
  import spi_pkg::*;

`ifdef SPI_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic sclk;
  logic reset;

  // DUT A: 8-bit, LSB first, depth 4
  logic       cs_a, mosi_a, miso_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, busy_a;
  logic [2:0] tx_level_a, rx_level_a;
  logic       tx_underrun_a, rx_overrun_a, clr_err_a;

  // DUT B: 16-bit, MSB first, depth 4
  logic        cs_b, mosi_b, miso_b;
  logic [15:0] tx_data_b, rx_data_b;
  logic        tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, busy_b;
  logic [2:0]  tx_level_b, rx_level_b;
  logic        tx_underrun_b, rx_overrun_b, clr_err_b;

  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1)) u_dut_a (
    .sclk(sclk), .reset(reset), .cs(cs_a), .mosi(mosi_a), .miso(miso_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .busy(busy_a), .tx_level(tx_level_a), .rx_level(rx_level_a),
    .tx_underrun(tx_underrun_a), .rx_overrun(rx_overrun_a), .clr_err(clr_err_a)
  );

  spi_slave_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .LSB_FIRST(1'b0)) u_dut_b (
    .sclk(sclk), .reset(reset), .cs(cs_b), .mosi(mosi_b), .miso(miso_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .busy(busy_b), .tx_level(tx_level_b), .rx_level(rx_level_b),
    .tx_underrun(tx_underrun_b), .rx_overrun(rx_overrun_b), .clr_err(clr_err_b)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  rx_q[$];
  bit          exp_ovr = 1'b0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_a();
    cs_a = 1'b1;
    @(negedge sclk);
  endtask

  task automatic push_a(input logic [7:0] w);
    tx_data_a  = w;
    tx_valid_a = 1'b1;
    @(negedge sclk);
    tx_valid_a = 1'b0;
  endtask

  // Drives one full frame on DUT A; leaves cs low so a following call is
  // back-to-back. The received word goes to the scoreboard unless RX is full.
  task automatic frame_a(input logic [7:0] mo, input logic [7:0] exp_miso,
                         input logic [7:0] exp_rx, input string nm);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk({nm, "_busy"}, 32'(busy_a), 32'd1);
      cs_a   = 1'b0;
      mosi_a = mo[i];
      #1;
      got[i] = miso_a;
      @(negedge sclk);
    end
    chk(nm, 32'(got), 32'(exp_miso));
    if (rx_q.size() < 4) rx_q.push_back(exp_rx);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_a(input string nm);
    logic [7:0] exp;
    chk({nm, "_valid"}, 32'(rx_valid_a), 32'd1);
    if (rx_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got pop with empty scoreboard expected entry", nm);
    end else begin
      exp = rx_q.pop_front();
      chk(nm, 32'(rx_data_a), 32'(exp));
    end
    rx_ready_a = 1'b1;
    @(negedge sclk);
    rx_ready_a = 1'b0;
  endtask

  task automatic clr_pulse_a();
    clr_err_a = 1'b1;
    @(negedge sclk);
    clr_err_a = 1'b0;
  endtask

  task automatic chk_reset_a(input string nm);
    chk({nm, "_miso"},     32'(miso_a),        32'd0);
    chk({nm, "_tx_ready"}, 32'(tx_ready_a),    32'd1);
    chk({nm, "_rx_valid"}, 32'(rx_valid_a),    32'd0);
    chk({nm, "_rx_data"},  32'(rx_data_a),     32'd0);
    chk({nm, "_busy"},     32'(busy_a),        32'd0);
    chk({nm, "_tx_level"}, 32'(tx_level_a),    32'd0);
    chk({nm, "_rx_level"}, 32'(rx_level_a),    32'd0);
    chk({nm, "_underrun"}, 32'(tx_underrun_a), 32'd0);
    chk({nm, "_overrun"},  32'(rx_overrun_a),  32'd0);
  endtask

  initial begin
    logic [15:0] got_b;
    logic [15:0] mo_b;

    vecs[0] = '{tx: 8'hA5, mosi: 8'h5A, exp_miso: 8'hA5, exp_rx: 8'h5A};
    vecs[1] = '{tx: 8'h3C, mosi: 8'hC3, exp_miso: 8'h3C, exp_rx: 8'hC3};
    vecs[2] = '{tx: 8'hF0, mosi: 8'h0F, exp_miso: 8'hF0, exp_rx: 8'h0F};
    vecs[3] = '{tx: 8'h01, mosi: 8'h80, exp_miso: 8'h01, exp_rx: 8'h80};

    cs_a = 1'b1; mosi_a = 1'b0; tx_data_a = '0; tx_valid_a = 1'b0;
    rx_ready_a = 1'b0; clr_err_a = 1'b0;
    cs_b = 1'b1; mosi_b = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    rx_ready_b = 1'b0; clr_err_b = 1'b0;
    reset = 1'b0;

    repeat (2) @(negedge sclk);
    chk_reset_a("reset_a");
    chk("reset_b_tx_ready", 32'(tx_ready_b), 32'd1);
    chk("reset_b_rx_level", 32'(rx_level_b), 32'd0);
    chk("reset_b_busy",     32'(busy_b),     32'd0);
    reset = 1'b1;
    @(negedge sclk);

    // DUT B: 16-bit MSB-first exchange
    tx_data_b  = 16'h8001;
    tx_valid_b = 1'b1;
    @(negedge sclk);
    tx_valid_b = 1'b0;
    @(negedge sclk);
    mo_b  = 16'h1234;
    got_b = '0;
    for (int i = 0; i < 16; i++) begin
      cs_b   = 1'b0;
      mosi_b = mo_b[15 - i];
      #1;
      got_b[15 - i] = miso_b;
      @(negedge sclk);
    end
    cs_b = 1'b1;
    chk("b16_miso",      32'(got_b),      32'h8001);
    chk("b16_rx_valid",  32'(rx_valid_b), 32'd1);
    chk("b16_rx_data",   32'(rx_data_b),  32'h1234);
    chk("b16_tx_level",  32'(tx_level_b), 32'd0);
    rx_ready_b = 1'b1;
    @(negedge sclk);
    rx_ready_b = 1'b0;
    chk("b16_rx_level",  32'(rx_level_b), 32'd0);

    // DUT A: fill TX, then back-to-back frames from the table
    for (int i = 0; i < 4; i++) push_a(vecs[i].tx);
    chk("txfull_level", 32'(tx_level_a), 32'd4);
    chk("txfull_ready", 32'(tx_ready_a), 32'd0);
    push_a(8'h99);
    chk("txfull_blocked_level", 32'(tx_level_a), 32'd4);
    idle_a();
    for (int i = 0; i < 4; i++) begin
      frame_a(vecs[i].mosi, vecs[i].exp_miso, vecs[i].exp_rx, $sformatf("vec%0d_miso", i));
    end
    idle_a();
    chk("vec_busy_after",  32'(busy_a),     32'd0);
    chk("vec_tx_level",    32'(tx_level_a), 32'd0);
    chk("vec_rx_level",    32'(rx_level_a), 32'd4);
    chk("vec_no_underrun", 32'(tx_underrun_a), 32'd0);
    for (int i = 0; i < 4; i++) pop_a($sformatf("vec%0d_rx", i));
    chk("vec_rx_drained", 32'(rx_level_a), 32'd0);

    // Underrun: TX empty sends zeros, flag sticky until clr_err
    frame_a(8'h96, 8'h00, 8'h96, "underrun_miso");
    idle_a();
    chk("underrun_flag", 32'(tx_underrun_a), 32'(ERR_EN));
    pop_a("underrun_rx");
    clr_pulse_a();
    chk("underrun_clr", 32'(tx_underrun_a), 32'd0);

    // clr_err on the same edge as a new underrun: set wins; frame aborted
    clr_err_a = 1'b1;
    cs_a      = 1'b0;
    mosi_a    = 1'b0;
    @(negedge sclk);
    clr_err_a = 1'b0;
    chk("set_wins_flag", 32'(tx_underrun_a), 32'(ERR_EN));
    idle_a();
    chk("set_wins_abort_busy", 32'(busy_a), 32'd0);
    chk("set_wins_no_rx", 32'(rx_level_a), 32'd0);
    clr_pulse_a();
    chk("set_wins_clr", 32'(tx_underrun_a), 32'd0);

    // Overrun: five frames without popping; fifth word dropped
    for (int k = 0; k < 5; k++) begin
      frame_a(8'(8'h11 * (k + 1)), 8'h00, 8'(8'h11 * (k + 1)), $sformatf("ovr%0d_miso", k));
    end
    idle_a();
    chk("ovr_rx_level", 32'(rx_level_a), 32'd4);
    chk("ovr_flag", 32'(rx_overrun_a), 32'(ERR_EN && exp_ovr));
    for (int k = 0; k < 4; k++) pop_a($sformatf("ovr%0d_rx", k));
    chk("ovr_drained", 32'(rx_level_a), 32'd0);
    clr_pulse_a();
    chk("ovr_clr", 32'(rx_overrun_a), 32'd0);
    chk("ovr_underrun_clr", 32'(tx_underrun_a), 32'd0);

    // Abort after 3 bits: no RX push, popped TX word lost
    push_a(8'h77);
    push_a(8'h88);
    idle_a();
    for (int i = 0; i < 3; i++) begin
      cs_a   = 1'b0;
      mosi_a = i[0];
      @(negedge sclk);
    end
    chk("abort_busy_mid", 32'(busy_a), 32'd1);
    idle_a();
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_rx_level", 32'(rx_level_a), 32'd0);
    chk("abort_tx_level", 32'(tx_level_a), 32'd1);
    idle_a();
    frame_a(8'hE7, 8'h88, 8'hE7, "abort_next_miso");
    idle_a();
    pop_a("abort_next_rx");
    chk("abort_tx_empty", 32'(tx_level_a), 32'd0);

    // Reset asserted mid-frame while a TX push is pending
    push_a(8'h12);
    push_a(8'h34);
    idle_a();
    for (int i = 0; i < 4; i++) begin
      cs_a   = 1'b0;
      mosi_a = 1'b1;
      @(negedge sclk);
    end
    tx_data_a  = 8'h56;
    tx_valid_a = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_a("midreset");
    @(negedge sclk);
    chk("midreset_push_blocked", 32'(tx_level_a), 32'd0);
    tx_valid_a = 1'b0;
    cs_a       = 1'b1;
    reset      = 1'b1;
    rx_q.delete();
    @(negedge sclk);
    chk("postreset_rx_level", 32'(rx_level_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised SPI slave with TX/RX FIFOs, configurable word width and bit order, back-to-back frames under one chip select, and sticky overrun/underrun reporting. It is the successor to the single-byte load/read slave: the host side pushes TX words and pops RX words through valid/ready handshakes instead of the load/read strobes. Everything runs on the SPI serial clock `sclk` (posedge only), with `cs` active-low.

## Interface
- DATA_W, 8: bits per SPI frame (≥2).
- FIFO_DEPTH, 4: entries per TX and RX FIFO (power of 2, ≥2).
- LSB_FIRST, 1: 1 = bit 0 shifted first on both lines; 0 = MSB first.
- sclk  in  1  SPI serial clock, sole clock, posedge only.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active-low, sampled on sclk.
- mosi  in  1  serial data in, sampled on posedge sclk.
- miso  out  1  serial data out; current TX bit while cs=0, else 0.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  push request for tx_data.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_W  RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request for RX FIFO.
- busy  out  1  frame in progress (state SHIFT).
- tx_level, rx_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancies.
- tx_underrun, rx_overrun  out  1  sticky error flags (see Configuration).
- clr_err  in  1  synchronous clear of sticky flags.

## Operation
- States: IDLE, SHIFT. Bit counter `cnt` 0..DATA_W-1.
- IDLE, every edge: tx_shift ← TX head, tx_loaded ← TX non-empty (zeros, tx_loaded=0 if empty). No pop.
- IDLE with cs=0 at an edge = first bit edge: sample mosi bit 0; shift tx_shift one position; pop TX if tx_loaded, else set tx_underrun; cnt←1; →SHIFT.
- SHIFT, cs=0: sample mosi, shift tx_shift, cnt++. On the edge sampling bit DATA_W-1: push assembled word into RX (if RX full: word dropped, rx_overrun set, contents unchanged); reload tx_shift/tx_loaded from TX head; cnt←0; →IDLE. Next edge with cs still low starts the next frame immediately (no gap bit).
- SHIFT, cs=1: abort. Partial RX word discarded, no push; already-popped TX word lost; cnt←0; →IDLE.
- miso = tx_shift[0] (LSB_FIRST=1) or tx_shift[DATA_W-1]; combinational, gated to 0 when cs=1, so bit 0 appears as soon as cs falls.
- RX bit placement: LSB_FIRST=1 shifts in at MSB and right-shifts; else at LSB and left-shifts. Received word equals transmitted word bit-for-bit.
- FIFOs: push when valid&&ready; pop when rx_valid&&rx_ready. Simultaneous push and pop on the same FIFO in one edge: both happen, level unchanged (allowed when full: TX push blocked by tx_ready=0 regardless). Pointers wrap modulo FIFO_DEPTH.
- clr_err and a new error on the same edge: flag set (set wins).

## Timing
- Reset (async assert, sync-to-sclk deassert by user): state IDLE, cnt 0, FIFOs empty, miso 0, tx_ready 1, rx_valid 0, rx_data 0, busy 0, levels 0, flags 0.
- TX push to miso visibility: word pushed at edge N is in tx_shift after edge N+1 (if IDLE, FIFO was empty).
- RX latency: rx_valid rises the edge after... precisely at the edge sampling bit DATA_W-1 (registered, visible after that edge).
- busy is high from the first-bit edge to the last-bit edge of a frame.

## Configuration
- SPI_SLAVE_ERR_EN defined: tx_underrun/rx_overrun are sticky registers cleared by clr_err.
- Not defined: both outputs tied 0, clr_err ignored; data behaviour (zeros sent on underrun, word dropped on overrun) unchanged.

## Structure
- Package spi_pkg: state enum (IDLE, SHIFT), bit-order constants, level-width helper function.
- Sub-module spi_sync_fifo (DATA_W, FIFO_DEPTH; push/pop, full/empty, level), instantiated twice for TX and RX.

## Test plan
- Push 8'hA5, 8'h3C; hold cs low 16 edges driving mosi 8'h5A, 8'hC3 LSB-first -> miso streams A5 then 3C, rx_data pops 5A then C3, tx_level 0.
- LSB_FIRST=0, DATA_W=16: push 16'h8001, master sends 16'h1234 MSB-first -> miso bit stream 1,0..0,1; rx_data 16'h1234.
- Frame with TX empty -> miso all 0, tx_underrun=1; clr_err pulse -> 0.
- Complete FIFO_DEPTH+1 frames without popping RX -> rx_level=4, rx_overrun=1, first 4 words intact.
- Raise cs after 3 bits -> no RX push, busy 0, cnt 0; next full frame received correctly.
- Assert reset mid-frame and during TX push -> all outputs at reset values immediately, levels 0.
